load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data and address width; only 32 is supported.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port Start_i  input  1  access request from execute stage, sampled only when Ready_o=1.
REQ-005 SHALL have port Addr_i  input  DATA_WIDTH  byte address, the ALU result.
REQ-006 SHALL have port WriteData_i  input  DATA_WIDTH  store data, rs2 value.
REQ-007 SHALL have port MemWrite_i  input  1  1=store, 0=load.
REQ-008 SHALL have port Funct3_i  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port Ready_o  output  1  unit idle, able to accept Start_i.
REQ-010 SHALL have port Done_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port ReadData_o  output  DATA_WIDTH  extended load result.
REQ-012 SHALL have port Fault_o  output  1  misaligned or illegal access, valid with Done_o.
REQ-013 SHALL have port MemReq_o  output  1  memory request, held until acknowledged.
REQ-014 SHALL have port MemWe_o  output  1  memory write enable.
REQ-015 SHALL have port MemAddr_o  output  DATA_WIDTH  word-aligned address (Addr_i with bits [1:0]=00).
REQ-016 SHALL have port MemWData_o  output  DATA_WIDTH  lane-shifted store data.
REQ-017 SHALL have port MemBe_o  output  4  byte enables, bit n = byte lane n.
REQ-018 SHALL have port MemAck_i  input  1  request accepted; MemRData_i valid in the same cycle.
REQ-019 SHALL have port MemRData_i  input  DATA_WIDTH  aligned read word.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, DONE, FAULT; Ready_o=1 only in IDLE.
REQ-021 SHALL, in IDLE with Start_i=1 and a legal aligned access, register address, lane data, byte enables, MemWe_o and Funct3_i and enter REQ.
REQ-022 SHALL, in IDLE with Start_i=1 and a misaligned (H with Addr_i[0]=1, W with Addr_i[1:0]!=00) or illegal (Funct3_i 011/11x, or store with 1xx) access, enter FAULT without asserting MemReq_o.
REQ-023 SHALL assert MemReq_o throughout REQ; MemAddr_o, MemWe_o, MemWData_o, MemBe_o SHALL stay stable while MemReq_o=1.
REQ-024 SHALL, in REQ with MemAck_i=1, capture extended load data into ReadData_o and enter DONE; MemAck_i in the first REQ cycle SHALL be honoured.
REQ-025 SHALL assert Done_o for exactly one cycle in DONE or FAULT, then return to IDLE; latency Start_i to Done_o = 2 cycles with zero-wait ack, +1 per wait cycle.
REQ-026 SHALL set Fault_o=1 only in FAULT, with ReadData_o=0 for that access.
REQ-027 SHALL drive byte enables: B 0001<<Addr[1:0]; H 0011<<Addr[1:0]; W 1111.
REQ-028 SHALL replicate store data to lanes: B {4{WriteData_i[7:0]}}, H {2{WriteData_i[15:0]}}, W unchanged.
REQ-029 SHALL select load lane by Addr[1:0] and sign-extend for B/H, zero-extend for BU/HU.
REQ-030 SHALL leave ReadData_o at 0 for stores and hold it otherwise until the next Done_o.
REQ-031 SHALL ignore Start_i while Ready_o=0; no request is queued.
REQ-032 SHALL drive MemReq_o, MemWe_o, MemBe_o to 0 outside REQ.

Reset
REQ-033 SHALL, on rst_i=1 at any time including mid-REQ, immediately enter IDLE with Ready_o=1 and all other outputs 0; an in-flight access is abandoned.
REQ-034 SHALL resume accepting Start_i on the first rising edge after rst_i deasserts.

Verification
REQ-035 SHALL cover LW Addr_i=0x100, ack after 2 wait cycles, MemRData_i=0xDEADBEEF -> MemAddr_o=0x100, MemBe_o=1111, Done_o on cycle 4, ReadData_o=0xDEADBEEF.
REQ-036 SHALL cover LB/LBU Addr_i=0x103, MemRData_i=0x80112233, zero-wait -> ReadData_o=0xFFFFFF80 / 0x00000080, Done_o 2 cycles after Start_i.
REQ-037 SHALL cover SH Addr_i=0x102, WriteData_i=0x1234ABCD -> MemAddr_o=0x100, MemBe_o=1100, MemWData_o=0xABCDABCD, MemWe_o=1, ReadData_o=0.
REQ-038 SHALL cover LW Addr_i=0x102 -> no MemReq_o, Done_o=1 and Fault_o=1 next cycle, ReadData_o=0.
REQ-039 SHALL cover rst_i pulse while MemReq_o=1 and MemAck_i=0 -> MemReq_o=0 and Ready_o=1 without a clock edge, no Done_o.
REQ-040 SHALL cover Start_i held high through a 3-wait-cycle access with changing Addr_i -> only the first access is issued, MemAddr_o stable until ack.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage access into a single handshaked memory word
// transaction. Stores are replicated onto the byte lanes with byte enables. Load data is
// taken from the addressed lane and sign- or zero-extended. Misaligned or illegal accesses
// finish in one cycle with Fault_o and never touch memory.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   Start_i             access request, sampled only while Ready_o=1
//   Addr_i              byte address
//   WriteData_i         store data
//   MemWrite_i          1=store, 0=load
//   Funct3_i            000 B, 001 H, 010 W, 100 BU, 101 HU
//   Ready_o             unit idle
//   Done_o              one-cycle completion pulse
//   ReadData_o          extended load result (0 for stores and faults)
//   Fault_o             misaligned/illegal access, valid with Done_o
//   MemReq_o            memory request, held until MemAck_i
//   MemWe_o             memory write enable
//   MemAddr_o           word-aligned address
//   MemWData_o          lane-replicated store data
//   MemBe_o             byte enables, bit n = lane n
//   MemAck_i            request accepted, MemRData_i valid in the same cycle
//   MemRData_i          aligned read word
module load_store_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  Start_i,
    input  logic [DATA_WIDTH-1:0] Addr_i,
    input  logic [DATA_WIDTH-1:0] WriteData_i,
    input  logic                  MemWrite_i,
    input  logic [2:0]            Funct3_i,
    output logic                  Ready_o,
    output logic                  Done_o,
    output logic [DATA_WIDTH-1:0] ReadData_o,
    output logic                  Fault_o,
    output logic                  MemReq_o,
    output logic                  MemWe_o,
    output logic [DATA_WIDTH-1:0] MemAddr_o,
    output logic [DATA_WIDTH-1:0] MemWData_o,
    output logic [3:0]            MemBe_o,
    input  logic                  MemAck_i,
    input  logic [DATA_WIDTH-1:0] MemRData_i
);

    typedef enum logic [1:0] {StIdle, StReq, StDone, StFault} state_e;

    state_e                r_state;
    logic                  r_done;
    logic                  r_fault;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [3:0]            r_mem_be;
    logic [2:0]            r_funct3;
    logic [1:0]            r_off;

    logic                  w_bad;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_lane;
    logic [DATA_WIDTH-1:0] w_load;

    // Request decode: 011 and 11x are never legal; unsigned sizes exist only for loads.
    always_comb begin
        w_bad = (Funct3_i == 3'b011) || (Funct3_i[2:1] == 2'b11)
             || (MemWrite_i && Funct3_i[2])
             || ((Funct3_i[1:0] == 2'b01) && Addr_i[0])
             || ((Funct3_i == 3'b010) && (Addr_i[1:0] != 2'b00));

        w_be    = 4'b1111;
        w_wdata = WriteData_i;
        case (Funct3_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << Addr_i[1:0];
                w_wdata = {4{WriteData_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << Addr_i[1:0];
                w_wdata = {2{WriteData_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction: move the addressed lane down to bit 0, then extend.
    always_comb begin
        w_lane = MemRData_i >> {r_off, 3'b000};
        case (r_funct3)
            3'b000:  w_load = {{(DATA_WIDTH-8){w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load = {{(DATA_WIDTH-16){w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load = {{(DATA_WIDTH-8){1'b0}}, w_lane[7:0]};
            3'b101:  w_load = {{(DATA_WIDTH-16){1'b0}}, w_lane[15:0]};
            default: w_load = MemRData_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= 4'b0000;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
        end else begin
            case (r_state)
                StIdle: begin
                    if (Start_i) begin
                        if (w_bad) begin
                            r_state <= StFault;
                            r_done  <= 1'b1;
                            r_fault <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_state     <= StReq;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= MemWrite_i;
                            r_mem_addr  <= {Addr_i[DATA_WIDTH-1:2], 2'b00};
                            r_mem_wdata <= w_wdata;
                            r_mem_be    <= w_be;
                            r_funct3    <= Funct3_i;
                            r_off       <= Addr_i[1:0];
                        end
                    end
                end
                StReq: begin
                    if (MemAck_i) begin
                        r_state   <= StDone;
                        r_done    <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_mem_be  <= 4'b0000;
                        r_rdata   <= r_mem_we ? '0 : w_load;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                    r_fault <= 1'b0;
                end
            endcase
        end
    end

    assign Ready_o    = (r_state == StIdle);
    assign Done_o     = r_done;
    assign Fault_o    = r_fault;
    assign ReadData_o = r_rdata;
    assign MemReq_o   = r_mem_req;
    assign MemWe_o    = r_mem_we;
    assign MemAddr_o  = r_mem_addr;
    assign MemWData_o = r_mem_wdata;
    assign MemBe_o    = r_mem_be;

endmodule
